// File: rtl/dbus_responder.sv
// Memory-side dbus responder: one transaction at a time, word-addressed storage with byte strobes,
// programmable accept delay and response latency, and a sticky initiator-protocol error flag.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for valid; request fields are latched on acceptance
// WAIT_A | counting down the accept delay
// ACK    | addr_ok cycle; write commits, old word is sampled
// WAIT_D | counting down the remaining response latency
// RESP   | data_ok cycle; sampled word is presented
module dbus_responder #(
    parameter int ADDR_WIDTH   = 10,
    parameter int ACCEPT_DELAY = 0,
    parameter int LATENCY      = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [71:0] dreq,
    output logic [65:0] dresp,
    output logic        err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_A,
        S_ACK,
        S_WAIT_D,
        S_RESP
    } state_t;

    // Request layout: {valid, addr[31:0], size[2:0], strobe[3:0], data[31:0]}
    logic        req_valid;
    logic [31:0] req_addr;
    logic [2:0]  unused_size;
    logic [3:0]  req_strobe;
    logic [31:0] req_data;

    assign req_valid   = dreq[71];
    assign req_addr    = dreq[70:39];
    assign unused_size = dreq[38:36];
    assign req_strobe  = dreq[35:32];
    assign req_data    = dreq[31:0];

    state_t      state;
    state_t      next_state;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic        latch_req;

    logic [31:0] lat_addr;
    logic [3:0]  lat_strobe;
    logic [31:0] lat_data;

    logic        addr_ok_q;
    logic        data_ok_q;
    logic [31:0] data_q;
    logic        err_q;
    logic        violation;

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_word;
    logic [ADDR_WIDTH-1:0] idx;

    assign idx = lat_addr[ADDR_WIDTH+1:2];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        latch_req  = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    latch_req = 1'b1;
                    cnt_next  = 4'(ACCEPT_DELAY);
                    if (ACCEPT_DELAY == 0) begin
                        next_state = S_ACK;
                    end else begin
                        next_state = S_WAIT_A;
                    end
                end
            end
            S_WAIT_A: begin
                if (cnt == 4'd1) begin
                    next_state = S_ACK;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            S_ACK: begin
                // ACK itself is the first latency cycle, so WAIT_D only covers LATENCY-1 cycles
                cnt_next = 4'(LATENCY - 1);
                if (LATENCY <= 1) begin
                    next_state = S_RESP;
                end else begin
                    next_state = S_WAIT_D;
                end
            end
            S_WAIT_D: begin
                if (cnt == 4'd1) begin
                    next_state = S_RESP;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            S_RESP: begin
                next_state = S_IDLE;
                cnt_next   = '0;
            end
            default: begin
                next_state = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        violation = 1'b0;
        if (state != S_IDLE) begin
            violation = !req_valid
                     || (req_addr   != lat_addr)
                     || (req_strobe != lat_strobe)
                     || (req_data   != lat_data);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lat_addr   <= '0;
            lat_strobe <= '0;
            lat_data   <= '0;
            addr_ok_q  <= 1'b0;
            data_ok_q  <= 1'b0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            if (latch_req) begin
                lat_addr   <= req_addr;
                lat_strobe <= req_strobe;
                lat_data   <= req_data;
            end
            addr_ok_q <= (next_state == S_ACK);
            data_ok_q <= (next_state == S_RESP);
            if (next_state == S_RESP) begin
                // With no WAIT_D the sample register is not loaded yet, so take the array directly
                data_q <= (state == S_ACK) ? mem[idx] : rd_word;
            end
            if (violation) begin
                err_q <= 1'b1;
            end
        end
    end

    // Storage is deliberately outside reset: a write reached in ACK survives a reset on that edge.
    always_ff @(posedge clk) begin
        if (state == S_ACK) begin
            rd_word <= mem[idx];
            for (int i = 0; i < 4; i++) begin
                if (lat_strobe[i]) begin
                    mem[idx][8*i +: 8] <= lat_data[8*i +: 8];
                end
            end
        end
    end

    // Response layout: {addr_ok, data_ok, 32'b0 reserved, data[31:0]}
    assign dresp = {addr_ok_q, data_ok_q, 32'd0, data_q};
    assign err   = err_q;

endmodule
